// File: rtl/ecap5_dwbdbg_master.sv
// Byte-stream debug bridge: decodes read/write commands and issues single pipelined Wishbone B4 accesses.
// Latency: cyc/stb rise the cycle after the last command byte; with zero stall and ack next cycle, tx_valid_o rises 2 cycles later.
// Backpressure: rx is stalled while a bus access or response is in progress; response bytes hold until tx_ready_i.
module ecap5_dwbdbg_master #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic        wb_ack_i,
   input  logic        wb_stall_i
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_WB_REQ, S_WB_WAIT, S_RESP
   } state_t;

   state_t          state, state_nxt;
   logic            we_q;
   logic [1:0]      byte_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic [39:0]     resp_sr;    // {D3,D2,D1,D0,status}, shifted out LSB first
   logic [2:0]      resp_left;
   logic            rx_fire, tx_fire, req_acc, wb_done, tmo_hit, cmd_ok;

   assign rx_ready_o = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
   assign rx_fire    = rx_valid_i && rx_ready_o;
   assign tx_valid_o = (state == S_RESP);
   assign tx_fire    = tx_valid_o && tx_ready_i;
   assign tx_data_o  = resp_sr[7:0];
   assign wb_cyc_o   = (state == S_WB_REQ) || (state == S_WB_WAIT);
   assign wb_stb_o   = (state == S_WB_REQ);
   assign wb_sel_o   = wb_cyc_o ? 4'hF : 4'h0;
   assign wb_we_o    = we_q;
   assign cmd_ok     = (rx_data_i == 8'h01) || (rx_data_i == 8'h02);
   assign req_acc    = wb_stb_o && !wb_stall_i;
   // an ack arriving together with request acceptance completes the access
   assign wb_done    = wb_ack_i && ((state == S_WB_WAIT) || req_acc);
   assign tmo_hit    = wb_cyc_o && !wb_done && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (rx_fire) state_nxt = cmd_ok ? S_ADDR : S_RESP;
         S_ADDR:    if (rx_fire && byte_cnt == 2'd3) state_nxt = we_q ? S_DATA : S_WB_REQ;
         S_DATA:    if (rx_fire && byte_cnt == 2'd3) state_nxt = S_WB_REQ;
         S_WB_REQ: begin
            if (wb_done || tmo_hit) state_nxt = S_RESP;
            else if (!wb_stall_i)   state_nxt = S_WB_WAIT;
         end
         S_WB_WAIT: if (wb_done || tmo_hit) state_nxt = S_RESP;
         S_RESP:    if (tx_fire && resp_left == 3'd1) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         we_q      <= 1'b0;
         byte_cnt  <= 2'd0;
         tmo_cnt   <= '0;
         resp_sr   <= 40'h0;
         resp_left <= 3'd0;
         wb_adr_o  <= 32'h0;
         wb_dat_o  <= 32'h0;
      end else begin
         tmo_cnt <= '0;
         case (state)
            S_IDLE: if (rx_fire) begin
               byte_cnt <= 2'd0;
               we_q     <= (rx_data_i == 8'h02);
               if (!cmd_ok) begin
                  resp_sr   <= {32'h0, 8'hEE};
                  resp_left <= 3'd1;
               end
            end
            S_ADDR: if (rx_fire) begin
               wb_adr_o[{byte_cnt, 3'b000} +: 8] <= rx_data_i;
               byte_cnt <= byte_cnt + 2'd1;
            end
            S_DATA: if (rx_fire) begin
               wb_dat_o[{byte_cnt, 3'b000} +: 8] <= rx_data_i;
               byte_cnt <= byte_cnt + 2'd1;
            end
            S_WB_REQ, S_WB_WAIT: begin
               tmo_cnt <= tmo_cnt + TW'(1);
               if (wb_done) begin
                  resp_sr   <= we_q ? 40'h0 : {wb_dat_i, 8'h00};
                  resp_left <= we_q ? 3'd1 : 3'd5;
               end else if (tmo_hit) begin
                  resp_sr   <= {32'h0, 8'hEE};
                  resp_left <= 3'd1;
               end
            end
            S_RESP: if (tx_fire) begin
               resp_sr   <= {8'h00, resp_sr[39:8]};
               resp_left <= resp_left - 3'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ecap5_dwbdbg_master.sv
// Bench for ecap5_dwbdbg_master: table of commands driven through a byte source, Wishbone slave model and byte sink.
// Expected bus requests and response bytes are queued when a command is issued and compared as the DUT produces them.
// All sampling and driving happens on the falling clock edge.
module tb_ecap5_dwbdbg_master;
   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic        rx_ready_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_stall_i;

   always #5 clk = ~clk;

   ecap5_dwbdbg_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
      .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
   );

   typedef struct {
      logic [7:0]  op;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [31:0] rdata;
      int          stall;     // cycles the slave stalls the request
      int          ack_mode;  // 0 never, 1 cycle after accept, 2 with accept
      int          bp;        // cycles the sink withholds tx_ready_i
      int          exp_cyc;   // required cycles with cyc high
   } vec_t;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
   } req_t;

   vec_t        vecs[8];
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_tx[$];
   req_t        exp_req[$];
   int          n_cmp = 0, n_bad = 0;

   int          tick_n = 0, acc_cnt, cyc_len, cyc_run, stb_cycles, first_stb, first_txv, last_rx;
   int          stall_budget = 0, ack_mode = 0, bp_left = 0;
   logic [31:0] rdata = 32'h0;
   logic        p_rxv = 0, p_rxr = 0, p_stb = 0, p_stall = 0, p_we = 0, p_txv = 0, p_txr = 0;
   logic [31:0] p_adr = 0, p_dat = 0;
   logic [3:0]  p_sel = 0;
   logic [7:0]  p_txd = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      logic ack_now;
      req_t r;
      @(negedge clk);
      tick_n++;
      ack_now = 1'b0;
      // transfers that happened at the rising edge just passed
      if (p_rxv && p_rxr) begin
         void'(rx_q.pop_front());
         last_rx = tick_n;
      end
      if (p_stb && !p_stall) begin
         acc_cnt++;
         ack_now = (ack_mode == 1);
         if (exp_req.size() == 0) check("unexpected request", 1, 0);
         else begin
            r = exp_req.pop_front();
            check("req adr", p_adr, r.adr);
            check("req we", p_we, r.we);
            check("req sel", p_sel, 4'hF);
            if (r.we) check("req dat", p_dat, r.dat);
         end
      end
      if (p_txv && p_txr) begin
         if (exp_tx.size() == 0) check("unexpected tx byte", p_txd, 8'h00 ^ 9'h100);
         else check("tx byte", p_txd, exp_tx.pop_front());
      end
      // observe current outputs
      if (wb_cyc_o) cyc_run++;
      else if (cyc_run > 0) begin
         cyc_len = cyc_run;
         cyc_run = 0;
      end
      if (wb_stb_o) begin
         stb_cycles++;
         if (exp_req.size() != 0) check("adr stable", wb_adr_o, exp_req[0].adr);
         if (first_stb < 0) first_stb = tick_n;
      end
      if (tx_valid_o && first_txv < 0) first_txv = tick_n;
      // drive inputs for the next rising edge
      if (wb_stb_o && stall_budget > 0) begin
         wb_stall_i = 1'b1;
         stall_budget--;
      end else wb_stall_i = 1'b0;
      wb_ack_i = ack_now || (ack_mode == 2 && wb_stb_o && !wb_stall_i);
      wb_dat_i = rdata;
      if (tx_valid_o && bp_left > 0) begin
         tx_ready_i = 1'b0;
         bp_left--;
         check("rx_ready during bp", rx_ready_o, 1'b0);
         if (exp_tx.size() != 0) check("tx_data held", tx_data_o, exp_tx[0]);
      end else tx_ready_i = 1'b1;
      rx_valid_i = (rx_q.size() != 0);
      rx_data_i  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      p_rxv = rx_valid_i; p_rxr = rx_ready_o; p_stb = wb_stb_o; p_stall = wb_stall_i;
      p_adr = wb_adr_o;   p_we = wb_we_o;     p_dat = wb_dat_o; p_sel = wb_sel_o;
      p_txv = tx_valid_o; p_txr = tx_ready_i; p_txd = tx_data_o;
   endtask

   task automatic clear_track();
      acc_cnt = 0; cyc_len = 0; cyc_run = 0; stb_cycles = 0;
      first_stb = -1; first_txv = -1; last_rx = -1;
   endtask

   task automatic push_cmd(input vec_t v);
      if (v.op == 8'h01 || v.op == 8'h02) exp_req.push_back('{v.adr, v.op == 8'h02, v.dat});
      rx_q.push_back(v.op);
      if (v.op == 8'h01 || v.op == 8'h02)
         for (int i = 0; i < 4; i++) rx_q.push_back(v.adr[8*i +: 8]);
      if (v.op == 8'h02)
         for (int i = 0; i < 4; i++) rx_q.push_back(v.dat[8*i +: 8]);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      bit okcmd;
      int n;
      okcmd = (v.op == 8'h01) || (v.op == 8'h02);
      clear_track();
      stall_budget = v.stall; ack_mode = v.ack_mode; rdata = v.rdata; bp_left = v.bp;
      push_cmd(v);
      if (!okcmd || v.ack_mode == 0) exp_tx.push_back(8'hEE);
      else begin
         exp_tx.push_back(8'h00);
         if (v.op == 8'h01)
            for (int i = 0; i < 4; i++) exp_tx.push_back(v.rdata[8*i +: 8]);
      end
      n = 0;
      while ((rx_q.size() != 0 || exp_tx.size() != 0) && n < 300) begin
         tick();
         n++;
      end
      check($sformatf("%s completes", tag), n < 300, 1'b1);
      check($sformatf("%s accepted reqs", tag), acc_cnt, okcmd ? 1 : 0);
      check($sformatf("%s stb cycles", tag), stb_cycles, okcmd ? v.stall + 1 : 0);
      check($sformatf("%s cyc cycles", tag), cyc_len, v.exp_cyc);
      check($sformatf("%s idle rx_ready", tag), rx_ready_o, 1'b1);
      check($sformatf("%s idle tx_valid", tag), tx_valid_o, 1'b0);
      check($sformatf("%s idle sel", tag), wb_sel_o, 4'h0);
      check($sformatf("%s idle cyc", tag), wb_cyc_o, 1'b0);
      if (okcmd && v.stall == 0 && v.ack_mode != 0) begin
         check($sformatf("%s stb latency", tag), first_stb - last_rx, 0);
         check($sformatf("%s tx latency", tag), first_txv - last_rx, (v.ack_mode == 2) ? 1 : 2);
      end
      rx_q.delete(); exp_tx.delete(); exp_req.delete();
   endtask

   initial begin
      vec_t rv;
      int n;
      vecs[0] = '{8'h02, 32'h00000010, 32'hDEADBEEF, 32'h0,        0, 1, 0, 2};
      vecs[1] = '{8'h01, 32'h40000004, 32'h0,        32'h12345678, 0, 1, 0, 2};
      vecs[2] = '{8'h01, 32'h00001000, 32'h0,        32'hA5A50F0F, 3, 1, 0, 5};
      vecs[3] = '{8'h01, 32'h20000000, 32'h0,        32'h0BADBEEF, 0, 0, 0, TMO};
      vecs[4] = '{8'h01, 32'h00000008, 32'h0,        32'hCAFEF00D, 0, 1, 2, 2};
      vecs[5] = '{8'h7F, 32'h0,        32'h0,        32'h0,        0, 1, 5, 0};
      vecs[6] = '{8'h02, 32'hFFFFFFFC, 32'h01020304, 32'h0,        0, 2, 1, 1};
      vecs[7] = '{8'h01, 32'h00000100, 32'h0,        32'h89ABCDEF, 1, 2, 0, 2};

      rst_i = 1'b0; rx_data_i = 8'h0; rx_valid_i = 1'b0; tx_ready_i = 1'b1;
      wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
      clear_track();
      #3;
      check("reset rx_ready", rx_ready_o, 1'b1);
      check("reset tx_valid", tx_valid_o, 1'b0);
      check("reset tx_data", tx_data_o, 8'h00);
      check("reset cyc", wb_cyc_o, 1'b0);
      check("reset stb", wb_stb_o, 1'b0);
      check("reset sel", wb_sel_o, 4'h0);
      check("reset we", wb_we_o, 1'b0);
      check("reset adr", wb_adr_o, 32'h0);
      check("reset dat", wb_dat_o, 32'h0);
      tick(); tick();
      #2 rst_i = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // reset while waiting for ack: bus and tx must drop without a clock edge
      clear_track();
      rv = '{8'h02, 32'h00000100, 32'h55AA55AA, 32'h0, 0, 0, 0, 0};
      stall_budget = 0; ack_mode = 0; bp_left = 0;
      push_cmd(rv);
      n = 0;
      while (acc_cnt == 0 && n < 100) begin
         tick();
         n++;
      end
      check("rst test request accepted", acc_cnt, 1);
      check("rst test cyc before", wb_cyc_o, 1'b1);
      check("rst test stb before", wb_stb_o, 1'b0);
      #2 rst_i = 1'b0;
      #1;
      check("async rst cyc", wb_cyc_o, 1'b0);
      check("async rst stb", wb_stb_o, 1'b0);
      check("async rst tx_valid", tx_valid_o, 1'b0);
      check("async rst sel", wb_sel_o, 4'h0);
      rx_q.delete(); exp_tx.delete(); exp_req.delete();
      tick(); tick();
      check("rst held tx_valid", tx_valid_o, 1'b0);
      #2 rst_i = 1'b1;
      run_vec(vecs[0], "post-reset write");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ecap5_dwbdbg_master.md
Name: ecap5_dwbdbg_master

Overview:
- Byte-stream-to-Wishbone debug bridge: decodes read/write commands from a byte source (UART receive path) and issues single pipelined Wishbone B4 transactions as a bus initiator.
- Returns status and read data as a byte stream to a byte sink (UART transmit path).
- Sits beside ecap5_dproc on the SoC bus, giving host-side access to BRAM, UART, timer and flash register space.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles from cyc assertion to ack before the access is aborted; ≥2.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-low
- rx_data_i  in  8  command byte in
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  bridge accepts byte; transfer when rx_valid_i && rx_ready_o
- tx_data_o  out  8  response byte out
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  sink accepts; transfer when tx_valid_o && tx_ready_i
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  byte enables, always 4'hF during a request
- wb_we_o  out  1  write enable
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_ack_i  in  1  acknowledge
- wb_stall_i  in  1  stall

Behaviour:
- Reset (rst_i low, async):
  - State is IDLE.
  - All wb_* outputs, tx_valid_o and tx_data_o are 0; internal address, data, counters and timeout are cleared.
  - rx_ready_o is 1, since it is 1 in IDLE/ADDR/DATA.
  - Reset mid-transaction drops cyc/stb immediately; no response byte is sent.
- Protocol (multi-byte fields LSB first):
  - Read: 0x01, A0..A3.
  - Write: 0x02, A0..A3, D0..D3.
  - Response: status byte (0x00 ok, 0xEE error); a successful read appends D0..D3.
- States:
  - IDLE: accept a byte.
    - 0x01: we=0, go to ADDR.
    - 0x02: we=1, go to ADDR.
    - Any other value: go to RESP with the single byte 0xEE.
  - ADDR: accept 4 bytes into adr[8k+7:8k] using a 2-bit counter. After the 4th byte: write goes to DATA, read goes to WB_REQ.
  - DATA: accept 4 bytes into wb_dat_o likewise, then go to WB_REQ.
  - WB_REQ: cyc=stb=1 with adr/we/sel stable.
    - Stay while wb_stall_i=1.
    - On the cycle stb && !stall, go to WB_WAIT next cycle with stb=0 and cyc=1.
    - If wb_ack_i is sampled in the same cycle as acceptance, treat it as WB_WAIT's ack.
  - WB_WAIT: cyc=1, stb=0.
    - On wb_ack_i: latch wb_dat_i (reads only), drop cyc next cycle, go to RESP with status 0x00.
  - Timeout:
    - The counter clears on entry to WB_REQ and increments each cycle in WB_REQ/WB_WAIT.
    - When it reaches TIMEOUT_CYCLES-1 without ack, drop cyc/stb next cycle and go to RESP with the single byte 0xEE.
    - Ack and the timeout in the same cycle: ack wins.
  - RESP: tx_valid_o=1 and tx_data_o = current response byte, both registered and held stable until tx_ready_i.
    - Each handshake advances to the next byte.
    - After the final byte: tx_valid_o=0, return to IDLE.
    - Response lengths: 1 byte for write ok, 5 for read ok, 1 for error.
- rx_ready_o is 0 in WB_REQ, WB_WAIT and RESP; no bytes are dropped, only back-pressured.
- Only one transaction is outstanding; cyc is never asserted outside WB_REQ/WB_WAIT.
- wb_adr_o and wb_we_o may be nonzero outside a cycle; wb_sel_o is 0 outside a cycle.
- Latency: last command byte accepted at cycle N, so cyc/stb rise at N+1. With zero stall and ack at N+2, tx_valid_o rises at N+3.

Test Plan:
- Write: bytes 02,10,00,00,00,EF,BE,AD,DE, stall=0, ack one cycle after stb.
  - Required: one cycle with adr=0x00000010, dat_o=0xDEADBEEF, we=1, sel=F.
  - Required response: single byte 00.
- Read: bytes 01,04,00,00,40, slave returns 0x12345678.
  - Required: adr=0x40000004, we=0.
  - Required response: 00,78,56,34,12.
- Stall: read with wb_stall_i high for 3 cycles.
  - Required: stb held 4 cycles with stable adr, exactly one accepted request, correct response.
- Timeout (TIMEOUT_CYCLES=8): read to a slave that never acks.
  - Required: cyc deasserts after 8 cycles; response single byte EE; next command succeeds.
- Back-pressure: bad command 0x7F, then tx_ready_i low 5 cycles.
  - Required: tx_data_o=EE held stable; rx_ready_o=0 throughout; after the handshake, return to IDLE.
- Reset in WB_WAIT: pull rst_i low asynchronously.
  - Required: cyc/stb/tx_valid_o go 0 without a clock edge.
  - Required: after release, a write completes normally.
